// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the pipeline hazard scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int REC_AW       = 5;
   localparam int REC_TW       = 2;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   localparam logic [REC_TW-1:0] TUSE_NEVER = 2'd3;

   typedef struct packed {
      logic              valid;
      logic [REC_AW-1:0] a3;
      logic [REC_TW-1:0] tnew;
   } stage_rec_t;

   function automatic logic [REC_TW-1:0] sat_dec(input logic [REC_TW-1:0] t);
      sat_dec = (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Advance a record by one stage: same producer, one cycle closer to its result.
   function automatic stage_rec_t age_rec(input stage_rec_t r);
      age_rec      = r;
      age_rec.tnew = sat_dec(r.tnew);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
// ============================================================================
// Module   : md_busy_counter
// Brief    : Down-counter tracking remaining busy cycles of the mult/div unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_busy_counter
   import pipe_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_load,
   input  logic i_div,
   output logic o_busy
);

   localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW        = $clog2(c_MAX_LAT + 1);

   localparam logic [CW-1:0] c_MULT = CW'(MULT_LAT);
   localparam logic [CW-1:0] c_DIV  = CW'(DIV_LAT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_div ? c_DIV : c_MULT;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Stall and forwarding-select generation from per-stage Tnew records.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
   import pipe_pkg::*;
#(
   parameter int NSTAGE   = 3,
   parameter int AW       = REC_AW,
   parameter int TW       = REC_TW,
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           d_valid,
   input  logic [AW-1:0]                  d_rs,
   input  logic [AW-1:0]                  d_rt,
   input  logic                           d_read_rs,
   input  logic                           d_read_rt,
   input  logic [TW-1:0]                  d_tuse_rs,
   input  logic [TW-1:0]                  d_tuse_rt,
   input  logic [AW-1:0]                  d_a3,
   input  logic [TW-1:0]                  d_tnew,
   input  logic                           d_mdft,
   input  logic                           d_md_start,
   input  logic                           d_md_div,
   output logic                           stall,
   output logic [$clog2(NSTAGE+1)-1:0]    fwd_rs_sel,
   output logic [$clog2(NSTAGE+1)-1:0]    fwd_rt_sel,
   output logic                           md_busy
);

   localparam int SW = $clog2(NSTAGE + 1);

   stage_rec_t          r_rec [1:NSTAGE];
   stage_rec_t          w_rec_in;
   logic [NSTAGE:1]     w_match_rs;
   logic [NSTAGE:1]     w_match_rt;
   logic                w_haz_rs;
   logic                w_haz_rt;
   logic [SW-1:0]       w_sel_rs;
   logic [SW-1:0]       w_sel_rt;
   logic                w_md_load;

   always_comb begin
      w_rec_in = '0;
      if (d_valid && !stall) begin
         w_rec_in.valid = 1'b1;
         w_rec_in.a3    = d_a3;
         w_rec_in.tnew  = sat_dec(d_tnew);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            r_rec[k] <= '0;
         end
      end else begin
         r_rec[1] <= w_rec_in;
         for (int k = 2; k <= NSTAGE; k++) begin
            r_rec[k] <= age_rec(r_rec[k-1]);
         end
      end
   end

   // Register 0 never matches, so writes to $0 can neither stall nor forward.
   for (genvar k = 1; k <= NSTAGE; k++) begin : g_match
      assign w_match_rs[k] = d_read_rs && (d_rs != '0) &&
                             r_rec[k].valid && (r_rec[k].a3 == d_rs);
      assign w_match_rt[k] = d_read_rt && (d_rt != '0) &&
                             r_rec[k].valid && (r_rec[k].a3 == d_rt);
   end

   // Oldest-to-youngest scan: the last hit is the youngest and shadows the rest.
   always_comb begin
      w_sel_rs = '0;
      w_sel_rt = '0;
      w_haz_rs = 1'b0;
      w_haz_rt = 1'b0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (w_match_rs[k]) begin
            w_sel_rs = (r_rec[k].tnew == '0) ? SW'(k) : '0;
            w_haz_rs = (d_tuse_rs != TUSE_NEVER) && (r_rec[k].tnew > d_tuse_rs);
         end
         if (w_match_rt[k]) begin
            w_sel_rt = (r_rec[k].tnew == '0) ? SW'(k) : '0;
            w_haz_rt = (d_tuse_rt != TUSE_NEVER) && (r_rec[k].tnew > d_tuse_rt);
         end
      end
   end

   assign stall      = d_valid && (w_haz_rs || w_haz_rt || (d_mdft && md_busy));
   assign fwd_rs_sel = w_sel_rs;
   assign fwd_rt_sel = w_sel_rt;
   assign w_md_load  = d_valid && d_md_start && !stall;

   md_busy_counter #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy_counter (
      .clk      (clk),
      .rst      (reset),
      .i_clear  (flush),
      .i_load   (w_md_load),
      .i_div    (d_md_div),
      .o_busy   (md_busy)
   );

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       d_valid;
   logic [4:0] d_rs;
   logic [4:0] d_rt;
   logic       d_read_rs;
   logic       d_read_rt;
   logic [1:0] d_tuse_rs;
   logic [1:0] d_tuse_rt;
   logic [4:0] d_a3;
   logic [1:0] d_tnew;
   logic       d_mdft;
   logic       d_md_start;
   logic       d_md_div;
   logic       stall;
   logic [1:0] fwd_rs_sel;
   logic [1:0] fwd_rt_sel;
   logic       md_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_read_rs  (d_read_rs),
      .d_read_rt  (d_read_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_a3       (d_a3),
      .d_tnew     (d_tnew),
      .d_mdft     (d_mdft),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .md_busy    (md_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      d_valid = 0; d_rs = 0; d_rt = 0; d_read_rs = 0; d_read_rt = 0;
      d_tuse_rs = 0; d_tuse_rt = 0; d_a3 = 0; d_tnew = 0;
      d_mdft = 0; d_md_start = 0; d_md_div = 0;
   endtask

   task automatic issue(input int rs, input int rt, input bit rrs, input bit rrt,
                        input int trs, input int trt, input int a3, input int tnew);
      idle();
      d_valid = 1;
      d_rs = 5'(rs); d_rt = 5'(rt); d_read_rs = rrs; d_read_rt = rrt;
      d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt); d_a3 = 5'(a3); d_tnew = 2'(tnew);
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   initial begin
      idle();
      reset = 1; flush = 0;
      tick(); tick();
      chk("rst_stall", stall, 0);
      chk("rst_fwd_rs", fwd_rs_sel, 0);
      chk("rst_fwd_rt", fwd_rt_sel, 0);
      chk("rst_busy", md_busy, 0);
      reset = 0;
      repeat (4) tick();
      chk("idle_stall", stall, 0);
      chk("idle_fwd_rs", fwd_rs_sel, 0);
      chk("idle_fwd_rt", fwd_rt_sel, 0);
      chk("idle_busy", md_busy, 0);

      // lw $8 then add rs=8 (Tuse 1): E record tnew 2 -> one stall cycle
      issue(29, 0, 1, 0, 1, 3, 8, 3); #1;
      chk("lw_issue_stall", stall, 0);
      tick();
      issue(8, 9, 1, 1, 1, 1, 10, 2); #1;
      chk("ldu_stall1", stall, 1);
      chk("ldu_fwd1", fwd_rs_sel, 0);
      tick(); #1;
      chk("ldu_stall2", stall, 0);
      chk("ldu_fwd2", fwd_rs_sel, 0);
      tick();
      issue(8, 0, 1, 0, 1, 3, 0, 2); #1;
      chk("ldu_fwd_w", fwd_rs_sel, 3);
      chk("ldu_stall3", stall, 0);
      tick();
      drain();

      // addi $9 then sub rt=9, then and rs=9
      issue(0, 0, 1, 0, 1, 3, 9, 2);
      tick();
      issue(0, 9, 1, 1, 1, 1, 11, 2); #1;
      chk("alu_stall", stall, 0);
      chk("alu_fwd_rt_e", fwd_rt_sel, 0);
      tick();
      issue(9, 0, 1, 0, 1, 3, 0, 2); #1;
      chk("alu_fwd_rs_m", fwd_rs_sel, 2);
      chk("alu_stall2", stall, 0);
      tick();
      drain();

      // jal $31 (tnew 1) then jr $31 (Tuse 0): forward from E
      issue(0, 0, 0, 0, 3, 3, 31, 1);
      tick();
      issue(31, 0, 1, 0, 0, 3, 0, 0); #1;
      chk("link_stall", stall, 0);
      chk("link_fwd_e", fwd_rs_sel, 1);
      tick();
      drain();

      // ori $5, lui $5, beq rs=5: youngest (lui) shadows ori
      issue(0, 0, 1, 0, 1, 3, 5, 2);
      tick();
      issue(0, 0, 0, 0, 3, 3, 5, 2);
      tick();
      issue(5, 0, 1, 1, 0, 0, 0, 0); #1;
      chk("shadow_stall", stall, 1);
      chk("shadow_fwd1", fwd_rs_sel, 0);
      tick(); #1;
      chk("shadow_stall2", stall, 0);
      chk("shadow_fwd2", fwd_rs_sel, 2);
      tick();
      drain();

      // Tuse "never": sw reads rt=8 right after lw $8 without stalling
      issue(29, 0, 1, 0, 1, 3, 8, 3);
      tick();
      issue(29, 8, 1, 1, 1, 3, 0, 0); #1;
      chk("never_stall", stall, 0);
      chk("never_fwd", fwd_rt_sel, 0);
      tick();
      drain();

      // write to $0 then read $0
      issue(0, 0, 1, 0, 1, 3, 0, 2);
      tick();
      issue(0, 0, 1, 1, 1, 1, 12, 2); #1;
      chk("r0_stall", stall, 0);
      chk("r0_fwd_rs", fwd_rs_sel, 0);
      chk("r0_fwd_rt", fwd_rt_sel, 0);
      tick();
      drain();

      // read flag low and invalid D both suppress the hazard
      issue(29, 0, 1, 0, 1, 3, 8, 3);
      tick();
      issue(8, 0, 0, 0, 0, 3, 0, 0); #1;
      chk("noread_stall", stall, 0);
      d_read_rs = 1; d_valid = 0; #1;
      chk("novalid_stall", stall, 0);
      tick();
      drain();

      // div then mflo: stalled exactly DIV_LAT cycles
      issue(1, 2, 1, 1, 1, 1, 0, 0);
      d_mdft = 1; d_md_start = 1; d_md_div = 1; #1;
      chk("div_stall", stall, 0);
      chk("div_busy0", md_busy, 0);
      tick();
      issue(0, 0, 0, 0, 3, 3, 12, 2);
      d_mdft = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("div_stall_c%0d", i), stall, 1);
         chk($sformatf("div_busy_c%0d", i), md_busy, 1);
         tick();
      end
      #1;
      chk("mflo_issue", stall, 0);
      chk("div_busy_end", md_busy, 0);
      tick();
      drain();

      // mult then mfhi: stalled exactly MULT_LAT cycles
      issue(1, 2, 1, 1, 1, 1, 0, 0);
      d_mdft = 1; d_md_start = 1;
      tick();
      issue(0, 0, 0, 0, 3, 3, 13, 2);
      d_mdft = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("mult_stall_c%0d", i), stall, 1);
         tick();
      end
      #1;
      chk("mfhi_issue", stall, 0);
      chk("mult_busy_end", md_busy, 0);
      tick();
      drain();

      // flush mid-div clears counter and records
      issue(1, 2, 1, 1, 1, 1, 0, 0);
      d_mdft = 1; d_md_start = 1; d_md_div = 1;
      tick();
      issue(29, 0, 1, 0, 1, 3, 8, 3); #1;
      chk("flush_pre_busy", md_busy, 1);
      tick();
      idle(); flush = 1;
      tick();
      flush = 0;
      issue(8, 0, 1, 0, 0, 3, 0, 0); #1;
      chk("flush_busy", md_busy, 0);
      chk("flush_stall", stall, 0);
      chk("flush_fwd", fwd_rs_sel, 0);
      tick();
      drain();

      // reset arriving with a D instruction: the clear wins
      issue(29, 0, 1, 0, 1, 3, 8, 3);
      reset = 1;
      tick();
      reset = 0;
      issue(8, 0, 1, 0, 0, 3, 0, 0); #1;
      chk("rstwin_stall", stall, 0);
      tick();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
